// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
package regfile_pkg;

  // Default pending-write counter width and the matching counter type.
  localparam int unsigned CNTW_DEF = 2;

  typedef logic [CNTW_DEF-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Address width for a register file of n entries (at least one bit).
  function automatic int unsigned aw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// One saturating pending-write counter: issue increments, writeback
// decrements, flush clears. Flags a writeback that arrives with nothing
// outstanding and no issue in the same cycle.
module regfile_sb_cnt
  import regfile_pkg::*;
#(
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            wb,
  input  logic            clr,
  output logic [CNTW-1:0] cnt,
  output logic            uflow
);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            dec;

  // Next count: clear wins, simultaneous inc/dec cancel, saturate at both ends.
  always_comb begin
    dec   = wb && (cnt_q != '0);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  assign cnt   = cnt_q;
  assign uflow = wb && (cnt_q == '0) && !inc;

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-read-port integer register file with optional
// writeback bypass and a per-register pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NREGS    = 32,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned BYPASS   = 1,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned CNTW     = CNTW_DEF,
  localparam int unsigned AW       = aw_of(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_stall,
  input  logic                flush,
  output logic                err
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [CNTW-1:0] cnt   [NREGS];
  logic [NREGS-1:0] uflow;
  logic            err_q;
  logic            err_d;
  logic            wa_zero;

  assign wa_zero = (ZERO_REG != 0) && (wa == '0);

  // Array next state: writeback lands unless it targets the hardwired zero.
  always_comb begin
    mem_d = mem_q;
    if (we && !wa_zero) begin
      mem_d[wa] = wd;
    end
  end

  // Sticky error: any writeback that found its counter empty.
  always_comb begin
    err_d = err_q | (|uflow);
  end

  // Array and error state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // A writeback to the same register frees a slot, so it never stalls.
  assign iss_stall = iss_valid && (cnt[iss_rd] == '1) && !(we && (wa == iss_rd));

  for (genvar r = 0; r < NREGS; r++) begin : g_cnt
    logic is_zero;
    logic inc;
    logic wb;

    assign is_zero = (ZERO_REG != 0) && (r == 0);
    assign inc     = iss_valid && (iss_rd == AW'(r)) && !iss_stall && !is_zero;
    assign wb      = we && (wa == AW'(r)) && !is_zero;

    regfile_sb_cnt #(
      .CNTW (CNTW)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc),
      .wb    (wb),
      .clr   (flush),
      .cnt   (cnt[r]),
      .uflow (uflow[r])
    );
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          zr;
    logic          hit;

    assign a   = ra[g*AW +: AW];
    assign zr  = (ZERO_REG != 0) && (a == '0);
    // hit implies wa == a and a is not the zero register, so wa is legal.
    assign hit = (BYPASS != 0) && we && (wa == a) && !zr;

    assign rd[g*XLEN +: XLEN] = zr ? '0 : (hit ? wd : mem_q[a]);
    assign rbusy[g] = !zr && (cnt[a] != '0) && !(hit && (cnt[a] == CNTW'(1)));
  end

endmodule
